// File: rtl/config_readback_pkg.sv
// Shared types and constants for the configuration scan-chain readback engine.
// The optional READBACK_CRC_EN build uses CRC_POLY/CRC_INIT from here.
package cfg_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, WAIT} state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/config_readback_if.sv
// Readback word stream: rd_data/rd_valid/rd_last from the engine, rd_ready from the consumer.
interface config_readback_if #(
   parameter int unsigned WORD_WIDTH = 8
);

   logic [WORD_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic                  rd_last;

   modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
   modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/config_readback_clk_gen.sv
// Phase counter for the chain shift clock: CLK_DIV cycles per phase, toggling
// config_clk at each phase end; stall parks the clock low and rewinds the phase.
module cfg_clk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall,
   output logic phase_end,
   output logic config_clk
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign phase_end = !stall && (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         config_clk <= 1'b0;
      end else if (stall) begin
         cnt        <= '0;
         config_clk <= 1'b0;
      end else if (phase_end) begin
         cnt        <= '0;
         config_clk <= ~config_clk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/config_readback.sv
// Non-destructive readback of the fabric config chain (config_out looped to config_in),
// packed LSB-first into words on a valid/ready stream. Define READBACK_CRC_EN for a CRC-16 output.
module config_readback
   import cfg_pkg::*;
#(
   parameter int unsigned CONFIG_WIDTH = 707,
   parameter int unsigned WORD_WIDTH   = 8,
   parameter int unsigned CLK_DIV      = 2
) (
   input  logic clk,
   input  logic rst_n,
`ifdef READBACK_CRC_EN
   output logic [15:0] crc,
`endif
   input  logic start,
   output logic busy,
   output logic done,
   input  logic config_out,
   output logic config_in,
   output logic config_clk,
   output logic config_en,
   config_readback_if.master rd
);

   localparam int unsigned NUM_WORDS = ceil_div(CONFIG_WIDTH, WORD_WIDTH);
   localparam int unsigned BW        = $clog2(CONFIG_WIDTH + 1);
   localparam int unsigned PW        = $clog2(WORD_WIDTH + 1);
   localparam int unsigned WW        = $clog2(NUM_WORDS + 1);

   state_t                state, state_nxt;
   logic [BW-1:0]         bit_cnt;
   logic [PW-1:0]         pack_cnt;
   logic [WW-1:0]         word_idx;
   logic [WORD_WIDTH-1:0] pack_reg;
   logic                  phase_end, stall, accept, sample, word_full, last_bit;

   assign stall     = (state == IDLE) || (state == WAIT);
   assign sample    = (state == SHIFT_LO) && phase_end;
   assign accept    = rd.rd_valid && rd.rd_ready;
   assign word_full = (pack_cnt == PW'(WORD_WIDTH));
   assign last_bit  = (bit_cnt == BW'(CONFIG_WIDTH));

   cfg_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .phase_end  (phase_end),
      .config_clk (config_clk)
   );

   assign busy        = (state != IDLE);
   assign config_en   = busy;
   assign config_in   = config_en & config_out;
   assign rd.rd_valid = (state == WAIT);
   assign rd.rd_data  = pack_reg;
   // The final word is identified by word index; in WAIT this coincides with bit_cnt == CONFIG_WIDTH.
   assign rd.rd_last  = rd.rd_valid && (word_idx == WW'(NUM_WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start)     state_nxt = SHIFT_LO;
         SHIFT_LO: if (phase_end) state_nxt = SHIFT_HI;
         SHIFT_HI: if (phase_end) state_nxt = (word_full || last_bit) ? WAIT : SHIFT_LO;
         WAIT:     if (accept)    state_nxt = rd.rd_last ? IDLE : SHIFT_LO;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done     <= 1'b0;
         bit_cnt  <= '0;
         pack_cnt <= '0;
         word_idx <= '0;
         pack_reg <= '0;
      end else begin
         done <= 1'b0;
         if ((state == IDLE) && start) begin
            bit_cnt  <= '0;
            pack_cnt <= '0;
            word_idx <= '0;
            pack_reg <= '0;
         end
         if (sample) begin
            for (int unsigned i = 0; i < WORD_WIDTH; i++)
               if (pack_cnt == PW'(i)) pack_reg[i] <= config_out;
            pack_cnt <= pack_cnt + 1'b1;
            bit_cnt  <= bit_cnt + 1'b1;
         end
         if (accept) begin
            pack_reg <= '0;
            pack_cnt <= '0;
            if (rd.rd_last) done     <= 1'b1;
            else            word_idx <= word_idx + 1'b1;
         end
      end
   end

`ifdef READBACK_CRC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if ((state == IDLE) && start) begin
         crc <= CRC_INIT;
      end else if (sample) begin
         crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ config_out) ? CRC_POLY : 16'h0000);
      end
   end
`endif

endmodule

// File: doc/config_readback.md
Name: config_readback

Overview:
- Hardware readback engine for the fabric configuration scan chain.
- Drives config_clk, config_en and config_in, and captures the fabric's config_out serial stream.
- Feeds config_out back into config_in, so the readback does not destroy the configuration: after CONFIG_WIDTH shifts the chain holds its original contents.
- Captured bits are packed into words and offered on a valid/ready stream for bitstream verification.

Parameters:
- CONFIG_WIDTH, 707: length of the fabric config chain in bits; must be >= 1.
- WORD_WIDTH, 8: width of the readback output word.
- CLK_DIV, 2: number of clk cycles in each config_clk phase (low and high); must be >= 1.
- NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH): derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a readback.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last word is accepted.
- config_out  input  1  serial output of the fabric chain.
- config_in  output  1  serial input to the fabric chain.
- config_clk  output  1  chain shift clock.
- config_en  output  1  chain shift enable.
- rd_data  output  WORD_WIDTH  packed readback bits, LSB = earliest bit.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  consumer accepts the word.
- rd_last  output  1  qualifies the final word of the readback.

Behaviour:
- Reset values (asynchronous): busy=0, done=0, config_clk=0, config_en=0, rd_valid=0, rd_last=0, rd_data=0, all counters 0, state IDLE.
- config_in is combinationally equal to config_out while config_en=1, and 0 otherwise.
- IDLE:
  - start=1 → SHIFT_LO. Set config_en=1, clear bit_cnt and pack count.
  - start while not IDLE is ignored.
- SHIFT_LO:
  - Hold config_clk=0 for CLK_DIV cycles.
  - On the last cycle of the phase, sample config_out into pack_reg[pack_cnt].
  - Then → SHIFT_HI, with config_clk=1 registered.
- SHIFT_HI:
  - Hold config_clk=1 for CLK_DIV cycles; bit_cnt increments on entry.
  - Exit conditions:
    - Pack word full, or bit_cnt == CONFIG_WIDTH → WAIT.
    - Otherwise → SHIFT_LO.
- WAIT:
  - config_clk=0; shifting is stalled.
  - rd_data = pack_reg, with unfilled upper bits zero. rd_valid=1. rd_last=1 iff bit_cnt == CONFIG_WIDTH.
  - On rd_valid && rd_ready:
    - If last: → IDLE, config_en=0, done=1 for one cycle, busy=0.
    - Otherwise: clear pack_reg and → SHIFT_LO.
- Backpressure: config_clk never rises while a word is pending. rd_data and rd_last stay stable while rd_valid && !rd_ready.
- Last word: with defaults it carries 707 mod 8 = 3 valid bits in [2:0]; [7:3] are 0.
- Bit order: bit k of the original config_bits vector appears in word k/WORD_WIDTH, bit k%WORD_WIDTH.
- Total config_clk rising edges per readback = CONFIG_WIDTH exactly.
- Reset mid-readback:
  - All outputs return to reset values immediately; the chain is left rotated by bit_cnt.
  - The chain must be reconfigured before any further readback is meaningful.

Optional Feature:
- Macro READBACK_CRC_EN.
- Defined:
  - Adds output crc [15:0] (reset 16'hFFFF).
  - On every sampled bit b: crc <= {crc[14:0],1'b0} ^ ((crc[15]^b) ? 16'h1021 : 0).
  - crc is reloaded to 16'hFFFF on an accepted start and is held stable after done.
- Undefined: no crc port and no CRC logic.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, WAIT};
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - the ceil-div function used for NUM_WORDS.
- One sub-module, cfg_clk_gen: phase counter that produces config_clk and a phase_end strobe from CLK_DIV, with a stall input.
- Packing, FSM and CRC stay in config_readback.

Test Plan:
- CONFIG_WIDTH=20, chain model preloaded 20'hA53C9, rd_ready=1 → words 8'hC9, 8'h53, 8'h0A (rd_last on the third); done pulses; chain model again reads 20'hA53C9.
- Default 707-bit chain, all ones → 88 words of 8'hFF, then the final word 8'h07 with rd_last=1; exactly 707 config_clk rising edges counted.
- rd_ready held low 50 cycles after the first word → no config_clk edge during the stall; rd_data is stable; readback resumes and completes correctly.
- start pulsed again while busy → ignored; word count unchanged; a single done.
- rst_n asserted after 10 shifts → config_en, config_clk, rd_valid and busy all 0 asynchronously in the same cycle; a new start after reset runs a full readback.
- READBACK_CRC_EN, 20-bit chain of all zeros → crc equals the bench's reference model value computed from the same polynomial and init; crc is unchanged after done.
